// File: rtl/dnn_pixel_streamer_pkg.sv
// Shared constants and read-side state encodings for the DNN pixel streamer.
package dnn_pixel_streamer_pkg;

  // Layer-1 geometry of the MNIST DNN that this streamer feeds.
  localparam int unsigned L1_NUM_WEIGHTS = 784;
  localparam int unsigned L1_IN_WIDTH    = 8;
  localparam int unsigned L1_DATA_WIDTH  = 16;
  localparam int unsigned L1_FRAC_SHIFT  = 7;
  localparam int unsigned DNN_OUT_WIDTH  = 32;

  localparam int unsigned STREAMER_NUM_PIXELS  = L1_NUM_WEIGHTS;
  localparam int unsigned STREAMER_PIX_WIDTH   = L1_IN_WIDTH;
  localparam int unsigned STREAMER_DATA_WIDTH  = L1_DATA_WIDTH;
  localparam int unsigned STREAMER_OUT_SHIFT   = L1_FRAC_SHIFT;
  localparam int unsigned STREAMER_CLASS_WIDTH = DNN_OUT_WIDTH;

  typedef enum logic [1:0] {
    RD_IDLE        = 2'd0,
    RD_STREAM      = 2'd1,
    RD_WAIT_RESULT = 2'd2
  } rd_state_t;

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/dnn_pingpong_ram.sv
// Two-bank image buffer: one write port, one registered read port, addressed as {bank, ptr}.
module dnn_pingpong_ram
  import dnn_pixel_streamer_pkg::*;
#(
  parameter int unsigned NUM_WORDS = STREAMER_NUM_PIXELS,
  parameter int unsigned WIDTH     = STREAMER_PIX_WIDTH,
  parameter int unsigned PTR_W     = ptr_width(NUM_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             rd_bank,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [2][NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_ptr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_bank][rd_ptr];
  end

endmodule

// File: rtl/dnn_pixel_streamer.sv
// Buffers 8-bit pixel frames in a ping-pong RAM and streams them as fixed-point words to the DNN.
// Optional frame-length checking on s_last is enabled with DNN_STREAMER_FRAME_CHECK_EN.
module dnn_pixel_streamer
  import dnn_pixel_streamer_pkg::*;
#(
  parameter int unsigned NUM_PIXELS  = STREAMER_NUM_PIXELS,
  parameter int unsigned PIX_WIDTH   = STREAMER_PIX_WIDTH,
  parameter int unsigned DATA_WIDTH  = STREAMER_DATA_WIDTH,
  parameter int unsigned OUT_SHIFT   = STREAMER_OUT_SHIFT,
  parameter int unsigned CLASS_WIDTH = STREAMER_CLASS_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  input  logic [PIX_WIDTH-1:0]   s_data,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic                   m_valid,
  output logic [DATA_WIDTH-1:0]  m_data,
  input  logic                   res_valid,
  input  logic [CLASS_WIDTH-1:0] res_data,
  output logic                   class_valid,
  output logic [CLASS_WIDTH-1:0] class_out,
  output logic                   busy,
  output logic                   err_len
);

  localparam int unsigned PTR_W = ptr_width(NUM_PIXELS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_PIXELS - 1);

  logic             wr_bank;
  logic [PTR_W-1:0] wr_ptr;
  logic [1:0]       bank_full;
  logic             rd_bank;
  logic [PTR_W-1:0] rd_ptr;
  rd_state_t        rd_state;
  logic             rd_q_valid;
  logic [PIX_WIDTH-1:0] rd_q;

  logic accept_c, wr_last_c, commit_c, wr_drop_c, rd_en_c, rd_clear_c;

  assign s_ready    = !reset && !bank_full[wr_bank];
  assign accept_c   = s_valid && s_ready;
  assign wr_last_c  = (wr_ptr == LAST_PTR);
  assign commit_c   = accept_c && wr_last_c;
  assign rd_en_c    = (rd_state == RD_STREAM);
  assign rd_clear_c = (rd_state == RD_WAIT_RESULT) && res_valid;
  assign busy       = (|bank_full) || (rd_state != RD_IDLE);

`ifdef DNN_STREAMER_FRAME_CHECK_EN
  // A short frame is discarded in place; a frame missing s_last is still committed.
  assign wr_drop_c = accept_c && s_last && !wr_last_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_len <= 1'b0;
    end else if (wr_drop_c || (commit_c && !s_last)) begin
      err_len <= 1'b1;
    end
  end
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign wr_drop_c     = 1'b0;
  assign err_len       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
    end else if (accept_c) begin
      if (commit_c) begin
        wr_bank <= ~wr_bank;
        wr_ptr  <= '0;
      end else if (wr_drop_c) begin
        wr_ptr  <= '0;
      end else begin
        wr_ptr  <= wr_ptr + 1'b1;
      end
    end
  end

  // Set and clear always target different banks: a bank is written only while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      bank_full <= '0;
    end else begin
      if (commit_c)   bank_full[wr_bank] <= 1'b1;
      if (rd_clear_c) bank_full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state    <= RD_IDLE;
      rd_bank     <= 1'b0;
      rd_ptr      <= '0;
      class_valid <= 1'b0;
      class_out   <= '0;
    end else begin
      class_valid <= 1'b0;
      unique case (rd_state)
        RD_IDLE: begin
          if (bank_full[rd_bank]) begin
            rd_state <= RD_STREAM;
            rd_ptr   <= '0;
          end
        end
        RD_STREAM: begin
          rd_ptr <= rd_ptr + 1'b1;
          if (rd_ptr == LAST_PTR) rd_state <= RD_WAIT_RESULT;
        end
        RD_WAIT_RESULT: begin
          if (res_valid) begin
            class_out   <= res_data;
            class_valid <= 1'b1;
            rd_bank     <= ~rd_bank;
            rd_state    <= RD_IDLE;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  dnn_pingpong_ram #(
    .NUM_WORDS (NUM_PIXELS),
    .WIDTH     (PIX_WIDTH),
    .PTR_W     (PTR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (accept_c),
    .wr_bank (wr_bank),
    .wr_ptr  (wr_ptr),
    .wr_data (s_data),
    .rd_en   (rd_en_c),
    .rd_bank (rd_bank),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_q)
  );

  // RAM read stage then conversion stage: output trails the read address by two cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q_valid <= 1'b0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      rd_q_valid <= rd_en_c;
      m_valid    <= rd_q_valid;
      if (rd_q_valid) m_data <= DATA_WIDTH'(rd_q) << OUT_SHIFT;
    end
  end

endmodule
